pea_host_loader: RTL and testbench

Host-side sequencer that sits between a 32-bit command/data stream (DMA or AXI-Stream bridge) and the PEA's configuration-memory, local-data-memory and start ports. It decodes command packets and performs four jobs: bulk-loading CFG words, bulk-loading LDM words, launching the array with a per-row start mask and waiting for completion, and streaming an LDM result region back out. It generalises bench-style PEA loading into a synthesizable, parametrised block with flow control, a completion timeout and error reporting.

---
 rtl/pea_host_loader.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_pea_host_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_host_loader.sv
// pea_host_loader
// Decodes a 32-bit command/data stream into PEA configuration traffic.
// It bulk-writes CFG and LDM words, launches the array and waits for done,
// and streams a region of LDM back out.
//
// Ports
//   CLK, RST (async, active-low)      clock and reset
//   s_valid/s_ready/s_data/s_last     command + payload stream in
//   CFG_addra/dina/ena/wea_out        CFG memory write port
//   CFG_incr_out                      increment latched from START
//   LDM_addra/dina/ena/wea_out        LDM memory port (write and read issue)
//   LDM_douta_in/_valid_in            LDM read return
//   start_out, done_in                array launch pulse / completion
//   m_valid/m_ready/m_data/m_last     result stream out
//   busy, err_out                     status; err bits = {opcode, timeout, framing}
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a command word
// LOAD     | collecting payload beats for CFGW / LDMW
// WAIT     | array started, waiting for done_in or timeout
// RD_ISSUE | LDM read strobe for the current word
// RD_WAIT  | waiting for LDM read data
// RD_OUT   | presenting one word on the result stream
// DRAIN    | discarding a bad packet up to s_last
module pea_host_loader #(
   parameter int DIN_W   = 32,
   parameter int CFG_W   = 96,
   parameter int LDM_W   = 160,
   parameter int CFG_AW  = 11,
   parameter int LDM_AW  = 8,
   parameter int START_W = 8,
   parameter int TMO_W   = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DIN_W-1:0]   s_data,
   input  logic               s_last,
   output logic [CFG_AW-1:0]  CFG_addra_out,
   output logic [CFG_W-1:0]   CFG_dina_out,
   output logic               CFG_ena_out,
   output logic               CFG_wea_out,
   output logic [7:0]         CFG_incr_out,
   output logic [LDM_AW-1:0]  LDM_addra_out,
   output logic [LDM_W-1:0]   LDM_dina_out,
   output logic               LDM_ena_out,
   output logic               LDM_wea_out,
   input  logic [LDM_W-1:0]   LDM_douta_in,
   input  logic               LDM_douta_valid_in,
   output logic [START_W-1:0] start_out,
   input  logic               done_in,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [LDM_W-1:0]   m_data,
   output logic               m_last,
   output logic               busy,
   output logic [2:0]         err_out
);

   localparam int BPC_CFG = (CFG_W + DIN_W - 1) / DIN_W;
   localparam int BPC_LDM = (LDM_W + DIN_W - 1) / DIN_W;
   localparam int BPC_MAX = (BPC_CFG > BPC_LDM) ? BPC_CFG : BPC_LDM;
   localparam int BUF_W   = BPC_MAX * DIN_W;
   localparam int BEAT_W  = $clog2(BPC_MAX + 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, RD_ISSUE, RD_WAIT, RD_OUT, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                s_ready_q, s_ready_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [11:0]         words_q, words_d;
   logic [15:0]         addr_q, addr_d;
   logic                sel_cfg_q, sel_cfg_d;
   logic [BUF_W-1:0]    buf_q, buf_d, buf_n;
   logic [2:0]          err_q, err_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [7:0]          incr_q, incr_d;
   logic [START_W-1:0]  start_q, start_d;
   logic                cfg_we_q, cfg_we_d;
   logic [CFG_AW-1:0]   cfg_addr_q, cfg_addr_d;
   logic [CFG_W-1:0]    cfg_din_q, cfg_din_d;
   logic                ldm_ena_q, ldm_ena_d;
   logic                ldm_we_q, ldm_we_d;
   logic [LDM_AW-1:0]   ldm_addr_q, ldm_addr_d;
   logic [LDM_W-1:0]    ldm_din_q, ldm_din_d;
   logic                m_valid_q, m_valid_d;
   logic [LDM_W-1:0]    m_data_q, m_data_d;
   logic                m_last_q, m_last_d;

   logic                fire;
   logic [3:0]          cmd_op;
   logic [11:0]         cmd_n;
   logic [15:0]         cmd_base;
   logic [15:0]         addr_inc;
   logic [BEAT_W-1:0]   last_beat;

   assign fire      = s_valid && s_ready_q;
   assign cmd_op    = s_data[31:28];
   assign cmd_n     = s_data[27:16];
   assign cmd_base  = s_data[15:0];
   assign addr_inc  = addr_q + 16'd1;
   assign last_beat = sel_cfg_q ? BEAT_W'(BPC_CFG - 1) : BEAT_W'(BPC_LDM - 1);

   // Current beat merged into the assembly buffer, so the write data on the
   // final beat already contains that beat.
   always_comb begin
      buf_n = buf_q;
      buf_n[int'(beat_q) * DIN_W +: DIN_W] = s_data;
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      words_d    = words_q;
      addr_d     = addr_q;
      sel_cfg_d  = sel_cfg_q;
      buf_d      = buf_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      incr_d     = incr_q;
      start_d    = '0;
      cfg_we_d   = 1'b0;
      cfg_addr_d = cfg_addr_q;
      cfg_din_d  = cfg_din_q;
      ldm_ena_d  = 1'b0;
      ldm_we_d   = 1'b0;
      ldm_addr_d = ldm_addr_q;
      ldm_din_d  = ldm_din_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_last_d   = m_last_q;

      case (state_q)
         IDLE: begin
            if (fire) begin
               case (cmd_op)
                  4'd0: err_d = '0;
                  4'd1, 4'd2: begin
                     sel_cfg_d = (cmd_op == 4'd1);
                     addr_d    = cmd_base;
                     words_d   = cmd_n;
                     beat_d    = '0;
                     if (cmd_n != 12'd0) state_d = LOAD;
                  end
                  4'd3: begin
                     incr_d  = cmd_base[15:8];
                     start_d = cmd_base[START_W-1:0];
                     tmo_d   = '0;
                     state_d = WAIT;
                  end
                  4'd4: begin
                     addr_d  = cmd_base;
                     words_d = cmd_n;
                     if (cmd_n != 12'd0) begin
                        state_d    = RD_ISSUE;
                        ldm_ena_d  = 1'b1;
                        ldm_addr_d = cmd_base[LDM_AW-1:0];
                     end
                  end
                  default: begin
                     err_d[2] = 1'b1;
                     // a lone illegal command word that already ends the packet has nothing to drain
                     if (!s_last) state_d = DRAIN;
                  end
               endcase
            end
         end
         LOAD: begin
            if (fire) begin
               buf_d = buf_n;
               if (s_last && !((beat_q == last_beat) && (words_q == 12'd1))) begin
                  err_d[0] = 1'b1;
                  beat_d   = '0;
                  state_d  = IDLE;
               end else if (beat_q == last_beat) begin
                  if (sel_cfg_q) begin
                     cfg_we_d   = 1'b1;
                     cfg_addr_d = addr_q[CFG_AW-1:0];
                     cfg_din_d  = buf_n[CFG_W-1:0];
                  end else begin
                     ldm_ena_d  = 1'b1;
                     ldm_we_d   = 1'b1;
                     ldm_addr_d = addr_q[LDM_AW-1:0];
                     ldm_din_d  = buf_n[LDM_W-1:0];
                  end
                  addr_d  = addr_inc;
                  words_d = words_q - 12'd1;
                  beat_d  = '0;
                  if (words_q == 12'd1) state_d = IDLE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            // tmo_q == 0 only in the start-pulse cycle, where done_in is ignored
            if (done_in && (tmo_q != '0)) begin
               state_d = IDLE;
            end else if (tmo_q == {TMO_W{1'b1}}) begin
               err_d[1] = 1'b1;
               state_d  = IDLE;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (LDM_douta_valid_in) begin
               m_data_d  = LDM_douta_in;
               m_last_d  = (words_q == 12'd1);
               m_valid_d = 1'b1;
               state_d   = RD_OUT;
            end
         end
         RD_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               words_d   = words_q - 12'd1;
               addr_d    = addr_inc;
               if (words_q == 12'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d    = RD_ISSUE;
                  ldm_ena_d  = 1'b1;
                  ldm_addr_d = addr_inc[LDM_AW-1:0];
               end
            end
         end
         DRAIN: begin
            if (fire && s_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      s_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DRAIN);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         s_ready_q  <= 1'b0;
         beat_q     <= '0;
         words_q    <= '0;
         addr_q     <= '0;
         sel_cfg_q  <= 1'b0;
         buf_q      <= '0;
         err_q      <= '0;
         tmo_q      <= '0;
         incr_q     <= '0;
         start_q    <= '0;
         cfg_we_q   <= 1'b0;
         cfg_addr_q <= '0;
         cfg_din_q  <= '0;
         ldm_ena_q  <= 1'b0;
         ldm_we_q   <= 1'b0;
         ldm_addr_q <= '0;
         ldm_din_q  <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_ready_q  <= s_ready_d;
         beat_q     <= beat_d;
         words_q    <= words_d;
         addr_q     <= addr_d;
         sel_cfg_q  <= sel_cfg_d;
         buf_q      <= buf_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         incr_q     <= incr_d;
         start_q    <= start_d;
         cfg_we_q   <= cfg_we_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_din_q  <= cfg_din_d;
         ldm_ena_q  <= ldm_ena_d;
         ldm_we_q   <= ldm_we_d;
         ldm_addr_q <= ldm_addr_d;
         ldm_din_q  <= ldm_din_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
      end
   end

   assign s_ready       = s_ready_q;
   assign CFG_addra_out = cfg_addr_q;
   assign CFG_dina_out  = cfg_din_q;
   assign CFG_ena_out   = cfg_we_q;
   assign CFG_wea_out   = cfg_we_q;
   assign CFG_incr_out  = incr_q;
   assign LDM_addra_out = ldm_addr_q;
   assign LDM_dina_out  = ldm_din_q;
   assign LDM_ena_out   = ldm_ena_q;
   assign LDM_wea_out   = ldm_we_q;
   assign start_out     = start_q;
   assign m_valid       = m_valid_q;
   assign m_data        = m_data_q;
   assign m_last        = m_last_q;
   assign busy          = (state_q != IDLE);
   assign err_out       = err_q;

endmodule

// File: tb/tb_pea_host_loader.sv
// Self-checking bench for pea_host_loader: directed cases plus randomized
// command mix checked against an expectation model built from command rules.
module tb_pea_host_loader;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         s_valid, s_last, done_in, m_ready, douta_valid;
   logic [31:0]  s_data;
   logic [159:0] douta;

   logic         s_ready, CFG_ena_out, CFG_wea_out, LDM_ena_out, LDM_wea_out;
   logic [10:0]  CFG_addra_out;
   logic [95:0]  CFG_dina_out;
   logic [7:0]   CFG_incr_out, LDM_addra_out, start_out;
   logic [159:0] LDM_dina_out, m_data;
   logic         m_valid, m_last, busy;
   logic [2:0]   err_out;

   logic         t_s_ready, t_cfg_ena, t_cfg_wea, t_ldm_ena, t_ldm_wea, t_m_valid, t_m_last, t_busy;
   logic [10:0]  t_cfg_addr;
   logic [95:0]  t_cfg_din;
   logic [7:0]   t_incr, t_ldm_addr, t_start;
   logic [159:0] t_ldm_din, t_m_data;
   logic [2:0]   t_err;

   always #5 CLK = ~CLK;

   pea_host_loader u_dut (
      .CLK(CLK), .RST(RST),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .CFG_addra_out(CFG_addra_out), .CFG_dina_out(CFG_dina_out),
      .CFG_ena_out(CFG_ena_out), .CFG_wea_out(CFG_wea_out), .CFG_incr_out(CFG_incr_out),
      .LDM_addra_out(LDM_addra_out), .LDM_dina_out(LDM_dina_out),
      .LDM_ena_out(LDM_ena_out), .LDM_wea_out(LDM_wea_out),
      .LDM_douta_in(douta), .LDM_douta_valid_in(douta_valid),
      .start_out(start_out), .done_in(done_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .err_out(err_out)
   );

   // Short-timeout copy sharing the same inputs, used for the timeout case.
   pea_host_loader #(.TMO_W(4)) u_tmo (
      .CLK(CLK), .RST(RST),
      .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data), .s_last(s_last),
      .CFG_addra_out(t_cfg_addr), .CFG_dina_out(t_cfg_din),
      .CFG_ena_out(t_cfg_ena), .CFG_wea_out(t_cfg_wea), .CFG_incr_out(t_incr),
      .LDM_addra_out(t_ldm_addr), .LDM_dina_out(t_ldm_din),
      .LDM_ena_out(t_ldm_ena), .LDM_wea_out(t_ldm_wea),
      .LDM_douta_in(douta), .LDM_douta_valid_in(douta_valid),
      .start_out(t_start), .done_in(done_in),
      .m_valid(t_m_valid), .m_ready(m_ready), .m_data(t_m_data), .m_last(t_m_last),
      .busy(t_busy), .err_out(t_err)
   );

   typedef struct { logic [10:0] a; logic [95:0]  d; } cfg_wr_t;
   typedef struct { logic [7:0]  a; logic [159:0] d; } ldm_wr_t;
   typedef struct { logic [159:0] d; logic l; } mbeat_t;

   cfg_wr_t      exp_cfg[$];
   ldm_wr_t      exp_ldm[$];
   logic [7:0]   exp_rd[$];
   mbeat_t       exp_m[$];
   logic [7:0]   exp_start[$];
   logic [159:0] pea_mem[256];

   int           checks = 0;
   int           failures = 0;
   logic [2:0]   model_err = 3'b000;
   int           rd_lat = 1;
   bit           bubble_en = 0;

   task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Word value = beats concatenated, least-significant beat first.
   function automatic logic [159:0] pack_beats(input logic [31:0] b[$], input int first, input int bpc);
      logic [159:0] r = '0;
      for (int k = 0; k < bpc; k++) r = r + ({128'd0, b[first + k]} * (160'd1 << (32 * k)));
      return r;
   endfunction

   // ---------------- compare process ----------------
   logic         hold_q = 0;
   logic [159:0] hold_d;
   logic         hold_l;
   always @(negedge CLK) begin
      cfg_wr_t ce; ldm_wr_t le; mbeat_t me; logic [7:0] ra; logic [7:0] sm;
      if (!RST) begin
         hold_q = 0;
      end else begin
         if (CFG_ena_out) begin
            check("cfg_write_expected", exp_cfg.size() != 0, 1);
            check("cfg_wea", CFG_wea_out, 1);
            if (exp_cfg.size() != 0) begin
               ce = exp_cfg.pop_front();
               check("cfg_addr", CFG_addra_out, ce.a);
               check("cfg_data", CFG_dina_out, ce.d);
            end
         end
         if (LDM_ena_out && LDM_wea_out) begin
            check("ldm_write_expected", exp_ldm.size() != 0, 1);
            if (exp_ldm.size() != 0) begin
               le = exp_ldm.pop_front();
               check("ldm_addr", LDM_addra_out, le.a);
               check("ldm_data", LDM_dina_out, le.d);
            end
         end
         if (LDM_ena_out && !LDM_wea_out) begin
            check("ldm_read_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) begin
               ra = exp_rd.pop_front();
               check("ldm_read_addr", LDM_addra_out, ra);
            end
         end
         if (hold_q) begin
            check("m_valid_held", m_valid, 1);
            check("m_data_stable", m_data, hold_d);
            check("m_last_stable", m_last, hold_l);
         end
         if (m_valid && m_ready) begin
            check("m_beat_expected", exp_m.size() != 0, 1);
            if (exp_m.size() != 0) begin
               me = exp_m.pop_front();
               check("m_data", m_data, me.d);
               check("m_last", m_last, me.l);
            end
         end
         hold_q = m_valid && !m_ready;
         hold_d = m_data;
         hold_l = m_last;
         if (start_out != 8'h00) begin
            check("start_expected", exp_start.size() != 0, 1);
            if (exp_start.size() != 0) begin
               sm = exp_start.pop_front();
               check("start_mask", start_out, sm);
            end
         end
      end
   end

   // ---------------- PEA read responder / m_ready toggling ----------------
   initial begin
      logic [7:0] a;
      douta_valid = 0;
      douta = '0;
      forever begin
         @(negedge CLK);
         if (RST && LDM_ena_out && !LDM_wea_out) begin
            a = LDM_addra_out;
            @(posedge CLK);
            repeat (rd_lat - 1) @(posedge CLK);
            #1 douta_valid = 1; douta = pea_mem[a];
            @(posedge CLK);
            #1 douta_valid = 0; douta = {5{$urandom}};
         end
      end
   end

   initial begin
      m_ready = 0;
      forever begin
         @(posedge CLK);
         #1 m_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [31:0] d, input logic l);
      int g = 0;
      if (bubble_en) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      s_data = d; s_last = l; s_valid = 1;
      @(negedge CLK);
      while (!s_ready && g < 500) begin g++; @(negedge CLK); end
      if (!s_ready) check("beat_accept_timeout", s_ready, 1);
      @(posedge CLK);
      #1 s_valid = 0; s_last = 0;
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge CLK);
      while (busy && g < 3000) begin g++; @(negedge CLK); end
      check("idle_reached", busy, 0);
      repeat (3) @(negedge CLK);
      check("cfg_q_empty", exp_cfg.size(), 0);
      check("ldm_q_empty", exp_ldm.size(), 0);
      check("rd_q_empty", exp_rd.size(), 0);
      check("m_q_empty", exp_m.size(), 0);
      check("start_q_empty", exp_start.size(), 0);
      check("err_out", err_out, model_err);
      @(posedge CLK); #1;
   endtask

   task automatic do_write(input bit is_cfg, input logic [15:0] base, input int n, input int trunc);
      logic [31:0]  beats[$];
      logic [159:0] w;
      int bpc, total, lim, nw;
      bpc = is_cfg ? 3 : 5;
      total = n * bpc;
      for (int k = 0; k < total; k++) beats.push_back($urandom);
      lim = (trunc >= 0) ? trunc : total - 1;
      nw  = (trunc >= 0) ? trunc / bpc : n;
      for (int i = 0; i < nw; i++) begin
         w = pack_beats(beats, i * bpc, bpc);
         if (is_cfg) exp_cfg.push_back('{a: 11'((int'(base) + i) % 2048), d: w[95:0]});
         else        exp_ldm.push_back('{a: 8'((int'(base) + i) % 256), d: w});
      end
      if (trunc >= 0) model_err[0] = 1'b1;
      send_beat({(is_cfg ? 4'h1 : 4'h2), 12'(n), base}, n == 0);
      if (n > 0) for (int k = 0; k <= lim; k++) send_beat(beats[k], k == lim);
      wait_idle();
   endtask

   task automatic do_read(input logic [15:0] base, input int n, input int lat);
      logic [7:0] a;
      rd_lat = lat;
      for (int i = 0; i < n; i++) begin
         a = 8'((int'(base) + i) % 256);
         exp_rd.push_back(a);
         exp_m.push_back('{d: pea_mem[a], l: (i == n - 1)});
      end
      send_beat({4'h4, 12'(n), base}, 1'b1);
      wait_idle();
   endtask

   task automatic do_start(input logic [15:0] base, input int dly);
      if (base[7:0] != 8'h00) exp_start.push_back(base[7:0]);
      send_beat({4'h3, 12'h000, base}, 1'b0);
      repeat (dly) @(posedge CLK);
      #1 done_in = 1;
      @(negedge CLK);
      check("busy_until_done", busy, 1);
      @(posedge CLK);
      #1 done_in = 0;
      @(negedge CLK);
      check("busy_after_done", busy, 0);
      check("cfg_incr", CFG_incr_out, base[15:8]);
      wait_idle();
   endtask

   task automatic do_illegal(input int k);
      logic [3:0] op;
      op = 4'($urandom_range(5, 15));
      model_err[2] = 1'b1;
      send_beat({op, 28'($urandom)}, k == 0);
      for (int i = 0; i < k; i++) send_beat($urandom, i == k - 1);
      wait_idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] b[$];
      logic [159:0] w;
      s_valid = 0; s_data = '0; s_last = 0; done_in = 0;
      for (int i = 0; i < 256; i++) pea_mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};

      repeat (2) @(negedge CLK);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_out, 0);
      check("rst_start", start_out, 0);
      check("rst_m_valid", m_valid, 0);
      @(posedge CLK); #1 RST = 1;
      @(negedge CLK);
      check("s_ready_before_first_edge", s_ready, 0);
      @(negedge CLK);
      check("s_ready_after_first_edge", s_ready, 1);
      @(posedge CLK); #1;

      // CFG load, 3 beats per word, back-to-back
      b = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
      w = pack_beats(b, 0, 3);
      check("model_pack_w0", w, 160'h333333332222222211111111);
      w = pack_beats(b, 3, 3);
      check("model_pack_w1", w, 160'h666666665555555544444444);
      exp_cfg.push_back('{a: 11'h040, d: 96'h333333332222222211111111});
      exp_cfg.push_back('{a: 11'h041, d: 96'h666666665555555544444444});
      send_beat(32'h1002_0040, 0);
      for (int k = 0; k < 6; k++) send_beat(b[k], k == 5);
      @(negedge CLK);
      check("cfg_last_write_pulse", CFG_ena_out, 1);
      check("idle_on_last_write", busy, 0);
      @(posedge CLK); #1;
      wait_idle();

      // LDM wrap 0xFF -> 0x00
      b.delete();
      for (int k = 0; k < 10; k++) b.push_back($urandom);
      exp_ldm.push_back('{a: 8'hFF, d: pack_beats(b, 0, 5)});
      exp_ldm.push_back('{a: 8'h00, d: pack_beats(b, 5, 5)});
      send_beat(32'h2002_00FF, 0);
      for (int k = 0; k < 10; k++) send_beat(b[k], k == 9);
      wait_idle();

      // START with done in the pulse cycle (ignored), then done 20 cycles later
      exp_start.push_back(8'h05);
      send_beat(32'h3000_0305, 0);
      done_in = 1;
      @(negedge CLK);
      check("start_pulse", start_out, 8'h05);
      check("start_incr", CFG_incr_out, 8'h03);
      @(posedge CLK); #1 done_in = 0;
      @(negedge CLK);
      check("start_one_cycle", start_out, 8'h00);
      check("done_ignored_in_start_cycle", busy, 1);
      repeat (19) @(posedge CLK);
      #1 done_in = 1;
      @(negedge CLK);
      check("busy_at_done", busy, 1);
      @(posedge CLK); #1 done_in = 0;
      @(negedge CLK);
      check("busy_falls_after_done", busy, 0);
      check("err_after_done", err_out, 3'b000);
      @(posedge CLK); #1;
      wait_idle();

      // Timeout on the TMO_W=4 instance
      send_beat(32'h0000_0000, 1); model_err = 3'b000;
      wait_idle();
      exp_start.push_back(8'h81);
      send_beat(32'h3000_0081, 0);
      repeat (15) @(posedge CLK);
      @(negedge CLK);
      check("tmo_not_yet_err", t_err[1], 0);
      check("tmo_not_yet_busy", t_busy, 1);
      @(negedge CLK);
      check("tmo_err", t_err[1], 1);
      check("tmo_idle", t_busy, 0);
      check("main_still_waiting", busy, 1);
      @(posedge CLK); #1 done_in = 1;
      @(posedge CLK); #1 done_in = 0;
      wait_idle();

      // Readback, latency 2
      rd_lat = 2;
      for (int i = 0; i < 3; i++) begin
         exp_rd.push_back(8'h10 + 8'(i));
         exp_m.push_back('{d: pea_mem[8'h10 + 8'(i)], l: (i == 2)});
      end
      send_beat(32'h4003_0010, 1);
      wait_idle();

      // Framing error: LDMW N=1, 2 beats
      send_beat(32'h2001_0000, 0);
      send_beat($urandom, 0);
      send_beat($urandom, 1);
      model_err = 3'b001;
      wait_idle();
      check("framing_err_literal", err_out, 3'b001);

      // Illegal opcode, then a normal command
      send_beat(32'h7000_0000, 0);
      for (int k = 0; k < 3; k++) send_beat($urandom, k == 2);
      model_err[2] = 1'b1;
      wait_idle();
      check("illegal_err_bit", err_out[2], 1);
      do_write(1, 16'h0123, 1, -1);
      send_beat(32'h0000_0000, 1);
      model_err = 3'b000;
      wait_idle();
      check("clr_literal", err_out, 3'b000);

      // Reset mid-LOAD
      send_beat(32'h1001_0020, 0);
      send_beat(32'hDEADBEEF, 0);
      send_beat(32'hCAFEF00D, 0);
      #1 RST = 0;
      #1;
      check("midrst_s_ready", s_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cfg_ena", CFG_ena_out, 0);
      check("midrst_incr", CFG_incr_out, 0);
      check("midrst_cfg_addr", CFG_addra_out, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1;
      model_err = 3'b000;
      exp_cfg.push_back('{a: 11'h050, d: 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA});
      send_beat(32'h1001_0050, 0);
      send_beat(32'hAAAAAAAA, 0);
      send_beat(32'hBBBBBBBB, 0);
      send_beat(32'hCCCCCCCC, 1);
      wait_idle();

      // Randomized command mix
      bubble_en = 1;
      for (int it = 0; it < 60; it++) begin
         int sel, n, tr;
         sel = $urandom_range(0, 9);
         n = $urandom_range(0, 3);
         tr = -1;
         case (sel)
            0, 1: begin
               if (n > 0 && $urandom_range(0, 3) == 0) tr = $urandom_range(0, n * 3 - 2);
               do_write(1, 16'($urandom), n, tr);
            end
            2, 3: begin
               if (n > 0 && $urandom_range(0, 3) == 0) tr = $urandom_range(0, n * 5 - 2);
               do_write(0, 16'($urandom), n, tr);
            end
            4, 5: do_read(16'($urandom), $urandom_range(0, 4), $urandom_range(1, 4));
            6: do_start(16'($urandom), $urandom_range(1, 40));
            7: do_illegal($urandom_range(0, 3));
            default: begin
               send_beat(32'h0000_0000, 1);
               model_err = 3'b000;
               wait_idle();
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
